multicycle_control: RTL

Multi-cycle MIPS main controller: a Moore FSM that sequences the shared datapath (one memory, one ALU, register file, IR/MDR/A/B/ALUOut registers) over 3-5 cycles per instruction. It replaces the single-cycle combinational control decode. It supports lw, sw, R-type, beq and j, with a wait-state handshake on memory. It drives all datapath mux selects and write enables; the ALU control block still decodes ALUOp together with funct.

---
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller.
// Moore FSM that sequences the shared datapath (memory, ALU, register file,
// IR/MDR/A/B/ALUOut) for lw, sw, R-type, beq and j, with a MemReady wait
// handshake on every memory access. ALUOp is decoded further by ALU control.
//
// Build option: define ADDI_EN to add addi support (ADDIEX/ADDIWB states).
// Without it, opcode 001000 is treated as illegal.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 into PC, load IR (waits on MemReady)
// DECODE | PC+(imm<<2) into ALUOut, dispatch on opcode
// MEMADR | A+signext address calculation for lw/sw
// MEMRD  | data read at ALUOut (waits on MemReady)
// MEMWB  | MDR written to rt
// MEMWR  | data write at ALUOut (waits on MemReady)
// EXEC   | R-type ALU operation on A,B
// RWB    | ALUOut written to rd
// BRANCH | compare A,B; take branch target from ALUOut if equal
// JUMP   | load PC with jump target
// ADDIEX | A+signext (ADDI_EN only)
// ADDIWB | ALUOut written to rt (ADDI_EN only)
// RST    | post-reset idle cycle, all outputs low
module multicycle_control (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] OpCode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Done,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_RST    = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e state_q, state_d;

  // State register; reset parks the FSM in RST, which forces every output low.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_RST;
    else          state_q <= state_d;
  end

  // Next-state and output decode; everything defaults to 0 and unknown
  // encodings (including disabled addi states) fall back to RST.
  always_comb begin
    state_d     = S_RST;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    Done        = 1'b0;
    Illegal     = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC and IR only load on the cycle the memory actually returns data.
        IRWrite = MemReady;
        PCWrite = MemReady;
        state_d = MemReady ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OpCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default: begin
            state_d = S_FETCH;
            Illegal = 1'b1;
            Done    = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // IR still holds the opcode; anything reaching here that is not lw is sw.
        state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        Done     = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Done     = MemReady;
        state_d  = MemReady ? S_FETCH : S_MEMWR;
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RWB;
      end

      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        Done     = 1'b1;
        state_d  = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        Done        = 1'b1;
        state_d     = S_FETCH;
      end

      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        Done     = 1'b1;
        state_d  = S_FETCH;
      end

`ifdef ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        RegWrite = 1'b1;
        Done     = 1'b1;
        state_d  = S_FETCH;
      end
`endif

      default: state_d = S_RST;
    endcase
  end

  assign State = state_q;

endmodule
